core_pipelined_adder: RTL and testbench
=======================================

Name: core_pipelined_adder

Overview:
- Parametrised, pipelined successor to the core combinational 64-bit adder.
- Splits the XLEN-bit add/subtract into STAGES carry-chained chunks, one chunk per pipeline stage.
- Uses a valid/ready handshake on input and output. Produces result, carry, signed overflow and zero flags.
- Used in the execute path wherever a wide add must not sit in a single cycle (address generation, 128-bit accumulate).

Parameters:
- XLEN, 64, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages. Legal values are 1..XLEN, with XLEN % STAGES == 0. Chunk width CW = XLEN/STAGES.

Ports:
- i_clk  input  1  core clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  operand beat valid.
- o_ready  output  1  block can accept a beat this cycle.
- i_srcA  input  XLEN  operand A.
- i_srcB  input  XLEN  operand B.
- i_sub  input  1  1: compute A - B (A + ~B + 1); 0: compute A + B + i_cin.
- i_cin  input  1  carry-in; ignored when i_sub=1.
- i_sat  input  1  signed saturation request; only honoured with CORE_ADDER_SATURATE_EN.
- o_valid  output  1  result beat valid.
- i_ready  input  1  downstream accepts the result.
- o_result  output  XLEN  sum/difference modulo 2^XLEN (or the saturated value).
- o_carry  output  1  carry-out of bit XLEN-1; for subtraction this means no-borrow.
- o_ovf  output  1  signed overflow: operand signs equal after B inversion and the result sign differs.
- o_zero  output  1  o_result == 0.

Behaviour:
- Stage k (0..STAGES-1) holds a valid bit v[k] plus registered operands, sub flag and partial result.
- Stage k adds chunk k (bits k*CW .. k*CW+CW-1) of A and (B XOR {XLEN{sub}}), plus the carry registered by stage k-1. Stage 0 uses carry-in = i_sub ? 1 : i_cin.
- Operand bits above a stage's chunk travel unchanged with the beat. Result bits already computed are carried forward with it.
- The last stage's registers drive the outputs directly: o_valid = v[STAGES-1], and o_result/o_carry/o_ovf/o_zero are registered. No combinational path from i_srcA/i_srcB to the outputs.
- Ready chain: rdy[STAGES] = i_ready and rdy[k] = !v[k] | rdy[k+1]; o_ready = rdy[0].
  - A beat enters stage 0 when i_valid & o_ready.
  - Stage k loads from k-1 when rdy[k]. v[k] is set to v[k-1] (or to i_valid for k=0).
- Latency: exactly STAGES cycles from input handshake to o_valid when i_ready is held high.
- Throughput: one beat per cycle with no bubbles while i_ready=1.
- Backpressure:
  - With i_ready=0 and all stages full, o_ready=0 and every stage register holds.
  - o_result and the flags stay stable while o_valid=1 and i_ready=0.
  - Empty stages collapse: a bubble in stage k lets stages 0..k-1 advance even while the output stalls.
- Simultaneous output pop and input push with the pipe full: both handshakes complete in the same cycle and the pipe stays full.
- i_valid=0 with o_ready=1: a bubble enters stage 0 (v[0]=0) and its data registers may hold or update (don't care).
- Reset (async assert, sync deassert handled upstream):
  - All v[k]=0 immediately, so o_valid=0.
  - o_result, o_carry, o_ovf = 0 and o_zero = 0.
  - Beats in flight are discarded, even mid-operation.
  - o_ready=1 in the first cycle after reset deasserts.
- STAGES=1: a single registered adder with latency 1.
- Wrap-around: results are modulo 2^XLEN. The carry goes only to o_carry, never into the result.

Optional Feature:
- Macro CORE_ADDER_SATURATE_EN.
- Defined: i_sat travels with the beat. In the last stage, if i_sat=1 and overflow occurred, o_result is forced to 0x7FF..F when A's sign is 0, or 0x800..0 when A's sign is 1. o_ovf still reports the raw overflow and o_zero reflects the saturated value.
- Not defined: i_sat is ignored (no flop, no logic), and o_result is always the raw modulo result.

Test Plan:
- XLEN=64, STAGES=4, i_ready=1, A=0xFFFF_FFFF_FFFF_FFFF, B=1, sub=0, cin=0 -> o_valid 4 cycles later, o_result=0, o_carry=1, o_zero=1, o_ovf=0. Exercises the full carry ripple across all chunks.
- A=0x7FFF_FFFF_FFFF_FFFF, B=1, add -> o_result=0x8000_0000_0000_0000, o_ovf=1, o_carry=0. With CORE_ADDER_SATURATE_EN and i_sat=1 -> o_result=0x7FFF_FFFF_FFFF_FFFF, o_ovf=1.
- sub=1, A=5, B=7 -> o_result=0xFFFF_FFFF_FFFF_FFFE, o_carry=0 (borrow). sub=1, A=7, B=5 -> o_result=2, o_carry=1.
- Stream 8 back-to-back beats (A=i, B=i) with i_ready=1 -> 8 results 0,2,..,14 on 8 consecutive cycles starting at cycle 4, with o_ready never low.
- Hold i_ready=0 while pushing -> after 4 accepted beats o_ready=0 and o_result stays stable. Raise i_ready for one cycle with i_valid=1 -> one beat pops and one enters, in order, with no loss or duplication.
- Push 2 beats, then assert i_rst_n=0 mid-flight -> o_valid=0 and all outputs 0 asynchronously. After release, no stale results appear and o_ready=1.

Source files
------------

// File: rtl/core_pipelined_adder.sv
// core_pipelined_adder: XLEN-bit add/sub split into STAGES carry-chained chunks.
// Optional signed saturation enabled by defining CORE_ADDER_SATURATE_EN.
module core_pipelined_adder #(
    parameter int XLEN   = 64,
    parameter int STAGES = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_srcA,
    input  logic [XLEN-1:0] i_srcB,
    input  logic            i_sub,
    input  logic            i_cin,
    input  logic            i_sat,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_carry,
    output logic            o_ovf,
    output logic            o_zero
);
    localparam int CW = XLEN / STAGES;
    localparam int L  = STAGES - 1;
    localparam int NQ = (STAGES > 1) ? STAGES - 1 : 1;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] rdy;

    logic [XLEN-1:0]   q_a [NQ];
    logic [XLEN-1:0]   q_b [NQ];
    logic [XLEN-1:0]   q_r [NQ];
    logic [NQ-1:0]     q_c;

    logic [XLEN-1:0]   in_a [STAGES];
    logic [XLEN-1:0]   in_b [STAGES];
    logic [XLEN-1:0]   in_r [STAGES];
    logic [XLEN-1:0]   nx_r [STAGES];
    logic [CW:0]       sum  [STAGES];
    logic [STAGES-1:0] in_c;
    logic [STAGES-1:0] in_v;
    logic [STAGES-1:0] nx_c;

    logic [XLEN-1:0]   fin;
    logic              fin_ovf;

`ifdef CORE_ADDER_SATURATE_EN
    logic [NQ-1:0]     q_s;
    logic [STAGES-1:0] in_s;
`else
    logic              unused_sat;
    assign unused_sat = i_sat;
`endif

    // A stage may advance if it or any later stage holds a bubble.
    always_comb begin : ready_chain
        logic acc;
        acc = i_ready;
        rdy = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc    = acc | ~v[k];
            rdy[k] = acc;
        end
    end

    assign o_ready = rdy[0];
    assign o_valid = v[L];

    always_comb begin : datapath
        in_a[0] = i_srcA;
        in_b[0] = i_srcB ^ {XLEN{i_sub}};
        in_r[0] = '0;
        in_c    = '0;
        in_v    = '0;
        nx_c    = '0;
        in_c[0] = i_sub | i_cin;
        in_v[0] = i_valid;
`ifdef CORE_ADDER_SATURATE_EN
        in_s    = '0;
        in_s[0] = i_sat;
`endif
        for (int k = 1; k < STAGES; k++) begin
            in_a[k] = q_a[k-1];
            in_b[k] = q_b[k-1];
            in_r[k] = q_r[k-1];
            in_c[k] = q_c[k-1];
            in_v[k] = v[k-1];
`ifdef CORE_ADDER_SATURATE_EN
            in_s[k] = q_s[k-1];
`endif
        end
        for (int k = 0; k < STAGES; k++) begin
            sum[k] = {1'b0, in_a[k][k*CW +: CW]}
                   + {1'b0, in_b[k][k*CW +: CW]}
                   + {{CW{1'b0}}, in_c[k]};
            nx_r[k] = in_r[k];
            nx_r[k][k*CW +: CW] = sum[k][CW-1:0];
            nx_c[k] = sum[k][CW];
        end
        // Overflow uses the already-inverted B sign.
        fin_ovf = (in_a[L][XLEN-1] == in_b[L][XLEN-1])
                & (nx_r[L][XLEN-1] != in_a[L][XLEN-1]);
        fin = nx_r[L];
`ifdef CORE_ADDER_SATURATE_EN
        if (in_s[L] & fin_ovf) begin
            fin = in_a[L][XLEN-1] ? {1'b1, {(XLEN-1){1'b0}}}
                                  : {1'b0, {(XLEN-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v        <= '0;
            q_c      <= '0;
`ifdef CORE_ADDER_SATURATE_EN
            q_s      <= '0;
`endif
            for (int k = 0; k < NQ; k++) begin
                q_a[k] <= '0;
                q_b[k] <= '0;
                q_r[k] <= '0;
            end
            o_result <= '0;
            o_carry  <= 1'b0;
            o_ovf    <= 1'b0;
            o_zero   <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES - 1; k++) begin
                if (rdy[k]) begin
                    v[k] <= in_v[k];
                    if (in_v[k]) begin
                        q_a[k] <= in_a[k];
                        q_b[k] <= in_b[k];
                        q_r[k] <= nx_r[k];
                        q_c[k] <= nx_c[k];
`ifdef CORE_ADDER_SATURATE_EN
                        q_s[k] <= in_s[k];
`endif
                    end
                end
            end
            if (rdy[L]) begin
                v[L] <= in_v[L];
                if (in_v[L]) begin
                    o_result <= fin;
                    o_carry  <= nx_c[L];
                    o_ovf    <= fin_ovf;
                    o_zero   <= (fin == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_core_pipelined_adder.sv
// tb_core_pipelined_adder: random and directed beats vs. an arithmetic model.
// Expected beats are queued at input handshake and compared at the output.
module tb_core_pipelined_adder;
    localparam int XLEN   = 64;
    localparam int STAGES = 4;

    logic            i_clk   = 1'b0;
    logic            i_rst_n = 1'b0;
    logic            i_valid = 1'b0;
    logic            i_sub   = 1'b0;
    logic            i_cin   = 1'b0;
    logic            i_sat   = 1'b0;
    logic            i_ready = 1'b0;
    logic [XLEN-1:0] i_srcA  = '0;
    logic [XLEN-1:0] i_srcB  = '0;
    logic            o_ready, o_valid, o_carry, o_ovf, o_zero;
    logic [XLEN-1:0] o_result;

    typedef struct {
        logic [XLEN-1:0] res;
        logic            carry;
        logic            ovf;
        logic            zero;
        int              cyc;
    } exp_t;

    exp_t expq[$];
    int   vectors   = 0;
    int   errors    = 0;
    int   cyc       = 0;
    bit   lat_chk   = 0;
    bit   stream_on = 0;
    bit   took      = 0;

    core_pipelined_adder #(.XLEN(XLEN), .STAGES(STAGES)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid),
        .o_ready(o_ready), .i_srcA(i_srcA), .i_srcB(i_srcB),
        .i_sub(i_sub), .i_cin(i_cin), .i_sat(i_sat),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
        .o_carry(o_carry), .o_ovf(o_ovf), .o_zero(o_zero)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [XLEN-1:0] a, b,
                                   input logic sub, cin, sat);
        exp_t e;
        logic [XLEN:0] full;
        logic sa, sb;
        if (sub) begin
            full[XLEN-1:0] = a - b;
            full[XLEN]     = (a >= b);
        end else begin
            full = {1'b0, a} + {1'b0, b} + {{XLEN{1'b0}}, cin};
        end
        sa = a[XLEN-1];
        sb = b[XLEN-1];
        e.res   = full[XLEN-1:0];
        e.carry = full[XLEN];
        e.ovf   = sub ? (sa != sb) && (e.res[XLEN-1] != sa)
                      : (sa == sb) && (e.res[XLEN-1] != sa);
`ifdef CORE_ADDER_SATURATE_EN
        if (sat && e.ovf)
            e.res = sa ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}};
`else
        if (sat) e.res = e.res;
`endif
        e.zero = (e.res == '0);
        e.cyc  = cyc;
        return e;
    endfunction

    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_valid) begin
                if (expq.size() == 0) begin
                    chk("spurious", XLEN'(o_valid), '0);
                end else begin
                    chk("result", o_result, expq[0].res);
                    chk("carry", XLEN'(o_carry), XLEN'(expq[0].carry));
                    chk("ovf", XLEN'(o_ovf), XLEN'(expq[0].ovf));
                    chk("zero", XLEN'(o_zero), XLEN'(expq[0].zero));
                    if (lat_chk && i_ready)
                        chk("latency", XLEN'(cyc - expq[0].cyc), XLEN'(STAGES));
                    if (i_ready) void'(expq.pop_front());
                end
            end
            if (stream_on) chk("stream_rdy", XLEN'(o_ready), XLEN'(1));
            took = i_valid && o_ready;
            if (took) expq.push_back(model(i_srcA, i_srcB, i_sub, i_cin, i_sat));
        end
    end

    task automatic send(input logic [XLEN-1:0] a, b, input logic s, c, t);
        int n = 0;
        i_valid = 1'b1;
        i_srcA  = a;
        i_srcB  = b;
        i_sub   = s;
        i_cin   = c;
        i_sat   = t;
        @(negedge i_clk);
        while (!o_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_ready) chk("send_timeout", XLEN'(o_ready), XLEN'(1));
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        chk("drain", XLEN'(expq.size()), '0);
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [XLEN-1:0] rnd();
        case ($urandom_range(0, 5))
            0: rnd = '1;
            1: rnd = {1'b0, {(XLEN-1){1'b1}}};
            2: rnd = {1'b1, {(XLEN-1){1'b0}}};
            3: rnd = '0;
            default: rnd = {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #3;
        chk("rst_valid", XLEN'(o_valid), '0);
        chk("rst_ready", XLEN'(o_ready), XLEN'(1));
        chk("rst_result", o_result, '0);
        chk("rst_zero", XLEN'(o_zero), '0);
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        lat_chk = 1;
        @(negedge i_clk);
        chk("rdy_after_rst", XLEN'(o_ready), XLEN'(1));
        @(posedge i_clk);
        #1;

        send('1, 64'd1, 0, 0, 0);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 0);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 1);
        send(64'h8000_0000_0000_0000, 64'd1, 1, 0, 1);
        send(64'd5, 64'd7, 1, 0, 0);
        send(64'd7, 64'd5, 1, 1, 0);
        send('1, 64'd0, 0, 1, 0);
        drain();

        stream_on = 1;
        for (int i = 0; i < 8; i++) send(XLEN'(i), XLEN'(i), 0, 0, 0);
        stream_on = 0;
        drain();

        lat_chk = 0;
        i_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) send(XLEN'(100 + i), 64'd3, 0, 0, 0);
        @(negedge i_clk);
        chk("full_rdy", XLEN'(o_ready), '0);
        repeat (3) @(negedge i_clk);
        @(posedge i_clk);
        #1;
        i_valid = 1'b1;
        i_srcA  = 64'd500;
        i_srcB  = 64'd1;
        i_sub   = 1'b1;
        i_ready = 1'b1;
        @(negedge i_clk);
        chk("pushpop_rdy", XLEN'(o_ready), XLEN'(1));
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        @(negedge i_clk);
        chk("still_full", XLEN'(o_ready), '0);
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        drain();

        for (int c = 0; c < 400; c++) begin
            if (!i_valid || took) begin
                i_valid = ($urandom_range(0, 3) != 0);
                i_srcA  = rnd();
                i_srcB  = rnd();
                i_sub   = 1'($urandom_range(0, 1));
                i_cin   = 1'($urandom_range(0, 1));
                i_sat   = 1'($urandom_range(0, 1));
            end
            i_ready = ($urandom_range(0, 3) != 0);
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        drain();

        i_ready = 1'b0;
        send(64'd11, 64'd22, 0, 0, 0);
        send(64'd33, 64'd44, 0, 0, 0);
        @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", XLEN'(o_valid), '0);
        chk("mid_rst_result", o_result, '0);
        chk("mid_rst_carry", XLEN'(o_carry), '0);
        chk("mid_rst_ovf", XLEN'(o_ovf), '0);
        chk("mid_rst_zero", XLEN'(o_zero), '0);
        expq.delete();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        @(negedge i_clk);
        chk("post_rst_rdy", XLEN'(o_ready), XLEN'(1));
        repeat (10) @(negedge i_clk);
        chk("post_rst_empty", XLEN'(expq.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
